// File: rtl/wt_mem_responder_pkg.sv
// Shared types and constants for the write-through memory responder.
// The response entry is sized from the package defaults; the top checks its parameters against them.
package wt_mem_responder_pkg;

    localparam int PkgDataWidth = 64;
    localparam int PkgTidWidth  = 2;
    localparam int PkgMemWords  = 1024;
    localparam int PkgLatency   = 2;

    localparam int OffW   = $clog2(PkgDataWidth / 8);
    localparam int IdxW   = $clog2(PkgMemWords);
    localparam int TimerW = $clog2(PkgLatency) + 1;

    typedef struct packed {
        logic                    we;
        logic [PkgTidWidth-1:0]  tid;
        logic [PkgDataWidth-1:0] rdata;
        logic                    err;
        logic [TimerW-1:0]       timer;
    } rsp_entry_t;

    // An address is in range when no bit at or above the word-index field is set.
    function automatic logic addr_in_range(input logic [63:0] addr, input int used_bits);
        return (addr >> used_bits) == 64'd0;
    endfunction

endpackage

// File: rtl/wt_mem_resp_fifo.sv
// Purpose: in-order response queue whose entries count down their own release timers.
// Latency: push visible at head next cycle; timers tick every cycle regardless of pop.
// Backpressure: push ignored when full, even if a pop happens in the same cycle.
module wt_mem_resp_fifo
    import wt_mem_responder_pkg::*;
#(
    parameter int Depth = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push,
    input  rsp_entry_t        push_dat,
    input  logic              pop,
    output rsp_entry_t        head_dat,
    output logic              full,
    output logic              empty
);

    localparam int PtrW = $clog2(Depth);

    rsp_entry_t        entries [Depth];
    logic [Depth-1:0]  occ;
    logic [PtrW-1:0]   wr_ptr;
    logic [PtrW-1:0]   rd_ptr;
    logic [PtrW:0]     cnt;
    logic              push_en;
    logic              pop_en;

    assign full     = (cnt == (PtrW + 1)'(Depth));
    assign empty    = (cnt == '0);
    assign push_en  = push & ~full;
    assign pop_en   = pop & ~empty;
    assign head_dat = entries[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            occ    <= '0;
        end else begin
            if (push_en) begin
                wr_ptr      <= wr_ptr + 1'b1;
                occ[wr_ptr] <= 1'b1;
            end
            if (pop_en) begin
                rd_ptr      <= rd_ptr + 1'b1;
                occ[rd_ptr] <= 1'b0;
            end
            case ({push_en, pop_en})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload needs no reset: occ masks stale slots from the countdown and the head.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < Depth; i++) begin
            if (push_en && wr_ptr == PtrW'(i)) begin
                entries[i] <= push_dat;
            end else if (occ[i] && entries[i].timer != '0) begin
                entries[i].timer <= entries[i].timer - TimerW'(1);
            end
        end
    end

endmodule

// File: rtl/wt_mem_responder.sv
// Purpose: memory-side responder; word array with byte-merged writes and tagged in-order responses.
// Latency: response valid Latency cycles after accept at the earliest.
// Backpressure: req_ready_o drops when MaxOutstanding responses are queued; rsp held until rsp_ready_i.
module wt_mem_responder
    import wt_mem_responder_pkg::*;
#(
    parameter int DataWidth      = 64,
    parameter int AddrWidth      = 64,
    parameter int TidWidth       = 2,
    parameter int MemWords       = 1024,
    parameter int Latency        = 2,
    parameter int MaxOutstanding = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_we_i,
    input  logic [AddrWidth-1:0]   req_addr_i,
    input  logic [DataWidth/8-1:0] req_be_i,
    input  logic [DataWidth-1:0]   req_wdata_i,
    input  logic [TidWidth-1:0]    req_tid_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic                   rsp_we_o,
    output logic [TidWidth-1:0]    rsp_tid_o,
    output logic [DataWidth-1:0]   rsp_rdata_o,
    output logic                   rsp_err_o
);

    localparam int ArrIdxW = $clog2(MemWords);
    localparam int NBytes  = DataWidth / 8;

    if (Latency < 1) begin : g_bad_latency
        $error("Latency must be at least 1");
    end
    if ((Latency - 1) >= (1 << TimerW)) begin : g_bad_timer
        $error("Latency does not fit the entry timer");
    end
    if ((MemWords & (MemWords - 1)) != 0 || MemWords < 2) begin : g_bad_words
        $error("MemWords must be a power of two");
    end
    if ((MaxOutstanding & (MaxOutstanding - 1)) != 0 || MaxOutstanding < 2) begin : g_bad_depth
        $error("MaxOutstanding must be a power of two");
    end
    if (DataWidth % 8 != 0 || DataWidth != PkgDataWidth || TidWidth != PkgTidWidth) begin : g_bad_width
        $error("DataWidth/TidWidth must match the response entry layout");
    end
    if (AddrWidth > 64 || AddrWidth < OffW + ArrIdxW) begin : g_bad_addr
        $error("AddrWidth out of supported range");
    end

    logic [DataWidth-1:0] mem [MemWords];
    logic [ArrIdxW-1:0]   idx;
    logic                 in_rng;
    logic                 accept;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    rsp_entry_t           push_dat;
    rsp_entry_t           head_dat;

    assign idx         = req_addr_i[OffW +: ArrIdxW];
    assign in_rng      = addr_in_range(64'(req_addr_i), OffW + ArrIdxW);
    assign req_ready_o = ~fifo_full;
    assign accept      = req_valid_i & req_ready_o & ~rst_i;

    // Earlier writes have already landed at a previous edge, so this read is RAW-ordered.
    always_comb begin
        push_dat       = '0;
        push_dat.we    = req_we_i;
        push_dat.tid   = req_tid_i;
        push_dat.err   = ~in_rng;
        push_dat.timer = TimerW'(Latency - 1);
        if (!req_we_i && in_rng) begin
            push_dat.rdata = mem[idx];
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept && req_we_i && in_rng) begin
            for (int b = 0; b < NBytes; b++) begin
                if (req_be_i[b]) begin
                    mem[idx][8*b +: 8] <= req_wdata_i[8*b +: 8];
                end
            end
        end
    end

    wt_mem_resp_fifo #(
        .Depth (MaxOutstanding)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push     (accept),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign rsp_valid_o = ~fifo_empty & (head_dat.timer == '0);
    assign pop         = rsp_valid_o & rsp_ready_i;

    assign rsp_we_o    = rsp_valid_o & head_dat.we;
    assign rsp_tid_o   = rsp_valid_o ? head_dat.tid   : '0;
    assign rsp_rdata_o = rsp_valid_o ? head_dat.rdata : '0;
    assign rsp_err_o   = rsp_valid_o & head_dat.err;

endmodule

// File: tb/tb_wt_mem_responder.sv
// Randomised bench for wt_mem_responder against a timestamped queue-and-array reference model.
module tb_wt_mem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 8;
    localparam int WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [63:0] req_addr;
    logic [7:0]  req_be;
    logic [63:0] req_wdata;
    logic [1:0]  req_tid;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_we;
    logic [1:0]  rsp_tid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    always #5 clk = ~clk;

    wt_mem_responder dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_be_i    (req_be),
        .req_wdata_i (req_wdata),
        .req_tid_i   (req_tid),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_we_o    (rsp_we),
        .rsp_tid_o   (rsp_tid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err)
    );

    typedef struct {
        logic        we;
        logic [1:0]  tid;
        logic [63:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] ref_mem [WORDS];
    int          cyc   = 0;
    int          total = 0;
    int          bad   = 0;
    int          acc_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive, compare against the model, then advance the model.
    task automatic step(input logic v, input logic we, input logic [63:0] addr, input logic [7:0] be,
                        input logic [63:0] wd, input logic [1:0] tid, input logic rr, input logic r);
        logic exp_vld;
        logic acc;
        logic pp;
        exp_t e;
        @(negedge clk);
        rst = r; req_valid = v; req_we = we; req_addr = addr; req_be = be;
        req_wdata = wd; req_tid = tid; rsp_ready = rr;
        #1;
        acc = 1'b0;
        pp  = 1'b0;
        if (!r) begin
            exp_vld = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
            chk("req_ready", 64'(req_ready), 64'(exp_q.size() < DEPTH));
            chk("rsp_valid", 64'(rsp_valid), 64'(exp_vld));
            if (exp_vld) begin
                chk("rsp_we",    64'(rsp_we),  64'(exp_q[0].we));
                chk("rsp_tid",   64'(rsp_tid), 64'(exp_q[0].tid));
                chk("rsp_err",   64'(rsp_err), 64'(exp_q[0].err));
                chk("rsp_rdata", rsp_rdata,    exp_q[0].rdata);
            end
            acc = v && (exp_q.size() < DEPTH);
            pp  = exp_vld && rr;
        end
        @(posedge clk);
        if (r) begin
            exp_q.delete();
        end else begin
            if (pp) void'(exp_q.pop_front());
            if (acc) begin
                acc_cnt++;
                e.we  = we;
                e.tid = tid;
                e.err = (addr >= 64'(WORDS * 8));
                e.rdata = 64'd0;
                e.due = cyc + LAT;
                if (!e.err) begin
                    if (we) begin
                        for (int b = 0; b < 8; b++)
                            if (be[b]) ref_mem[addr[12:3]][8*b +: 8] = wd[8*b +: 8];
                    end else begin
                        e.rdata = ref_mem[addr[12:3]];
                    end
                end
                exp_q.push_back(e);
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 64'd0, 8'h00, 64'd0, 2'd0, rr, 1'b0);
    endtask

    task automatic rd(input logic [63:0] addr, input logic [1:0] tid, input logic rr);
        step(1'b1, 1'b0, addr, 8'h00, 64'd0, tid, rr, 1'b0);
    endtask

    task automatic wr(input logic [63:0] addr, input logic [7:0] be, input logic [63:0] wd,
                      input logic [1:0] tid, input logic rr);
        step(1'b1, 1'b1, addr, be, wd, tid, rr, 1'b0);
    endtask

    initial begin
        int a0;
        logic [63:0] ra;
        int r;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_be = '0;
        req_wdata = '0; req_tid = '0; rsp_ready = 1'b0;

        step(1'b0, 1'b0, 64'd0, 8'h00, 64'd0, 2'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 64'd0, 8'h00, 64'd0, 2'd0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_ready", 64'(req_ready), 64'd1);
        chk("reset_valid", 64'(rsp_valid), 64'd0);
        chk("reset_tid",   64'(rsp_tid),   64'd0);
        chk("reset_rdata", rsp_rdata,      64'd0);

        // Give every word a known value so any read can be predicted.
        for (int i = 0; i < WORDS; i++)
            wr(64'(i * 8), 8'hFF, {$urandom, $urandom}, 2'(i), 1'b1);
        idle(4, 1'b1);

        // Full write then read-after-write, partial merge, out-of-range access.
        wr(64'h40, 8'hFF, 64'hDEADBEEF_CAFEF00D, 2'd1, 1'b1);
        rd(64'h40, 2'd2, 1'b1);
        idle(4, 1'b1);
        wr(64'h40, 8'h0F, 64'h11111111_22222222, 2'd3, 1'b1);
        rd(64'h40, 2'd0, 1'b1);
        idle(4, 1'b1);
        chk("merged_word", ref_mem[8], 64'hDEADBEEF_22222222);
        wr(64'h2000, 8'hFF, 64'h0BAD0BAD_0BAD0BAD, 2'd1, 1'b1);
        rd(64'h2000, 2'd2, 1'b1);
        rd(64'h0, 2'd3, 1'b1);
        idle(4, 1'b1);

        // Fill the queue with stalled responses, then a pop must not admit a push that cycle.
        for (int i = 0; i < 9; i++) rd(64'(i * 8), 2'(i), 1'b0);
        chk("full_count", 64'(exp_q.size()), 64'(DEPTH));
        a0 = acc_cnt;
        rd(64'h40, 2'd0, 1'b1);
        chk("no_bypass", 64'(acc_cnt - a0), 64'd0);
        rd(64'h40, 2'd0, 1'b0);
        chk("accept_after_pop", 64'(acc_cnt - a0), 64'd1);
        idle(12, 1'b1);

        // Three responses held back, then drained back-to-back.
        rd(64'h100, 2'd1, 1'b0);
        rd(64'h108, 2'd2, 1'b0);
        rd(64'h110, 2'd3, 1'b0);
        idle(10, 1'b0);
        idle(3, 1'b1);
        chk("drained", 64'(exp_q.size()), 64'd0);

        // Reset with work outstanding discards it.
        for (int i = 0; i < 4; i++) rd(64'(i * 8), 2'(i), 1'b0);
        step(1'b0, 1'b0, 64'd0, 8'h00, 64'd0, 2'd0, 1'b1, 1'b1);
        idle(6, 1'b1);

        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      ra = 64'h2000 + 64'($urandom_range(0, 'hFFFF));
            else if (r == 1) ra = {$urandom, $urandom};
            else             ra = 64'($urandom_range(0, 'h1FFF));
            if ($urandom_range(0, 299) == 0)
                step(1'b0, 1'b0, 64'd0, 8'h00, 64'd0, 2'd0, 1'b1, 1'b1);
            else
                step($urandom_range(0, 9) < 7, 1'($urandom), ra, 8'($urandom), {$urandom, $urandom},
                     2'($urandom), $urandom_range(0, 9) < 6, 1'b0);
        end
        idle(20, 1'b1);
        chk("final_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
